// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and
// step-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Counter must hold values up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the working register left, trial-subtract
// the divisor magnitude from the upper part, keep or restore.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] work,
    input  logic [WIDTH-1:0]   divisor_mag,
    output logic [2*WIDTH-1:0] work_next
);

    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The partial remainder is always below the divisor, so a successful
    // trial difference fits back into WIDTH bits.
    always_comb begin
        upper     = work[2*WIDTH-1:WIDTH-1];
        lower     = {work[WIDTH-2:0], 1'b0};
        fits      = (upper >= {1'b0, divisor_mag});
        trial     = WIDTH'(upper - {1'b0, divisor_mag});
        work_next = '0;
        if (fits) begin
            work_next = {trial, lower[WIDTH-1:1], 1'b1};
        end else begin
            work_next = {upper[WIDTH-1:0], lower[WIDTH-1:1], 1'b0};
        end
    end

endmodule

// File: rtl/streamlined_divider_param.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake,
// truncating signed results and divide-by-zero / overflow flags.
//
// state | meaning
// IDLE  | waiting for start_sig; done_sig/busy fall here
// CALC  | WIDTH restoring steps on magnitudes
// FIX   | sign correction, special cases, register results
// DONE  | raise done_sig (seen in the following cycle)
module streamlined_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_sig,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done_sig,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int             CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t         state, state_nxt;
    logic [CW-1:0]      step_cnt;
    logic [2*WIDTH-1:0] work, work_next;
    logic [WIDTH-1:0]   b_mag, a_raw;
    logic               sm_r, a_sgn, b_sgn, div0_r, ovf_r;

    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .work        (work),
        .divisor_mag (b_mag),
        .work_next   (work_next)
    );

    always_comb begin
        a_neg_in = signed_mode & dividend[WIDTH-1];
        b_neg_in = signed_mode & divisor[WIDTH-1];
        a_mag_in = a_neg_in ? -dividend : dividend;
        b_mag_in = b_neg_in ? -divisor  : divisor;
    end

    // Remainder follows the dividend's sign (C truncation semantics).
    always_comb begin
        q_mag = work[WIDTH-1:0];
        r_mag = work[2*WIDTH-1:WIDTH];
        q_fix = (sm_r && (a_sgn ^ b_sgn)) ? -q_mag : q_mag;
        r_fix = (sm_r && a_sgn) ? -r_mag : r_mag;
        if (div0_r) begin
            q_fix = '1;
            r_fix = a_raw;
        end else if (ovf_r) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sig) state_nxt = CALC;
            CALC:    if (step_cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt  <= '0;
            work      <= '0;
            b_mag     <= '0;
            a_raw     <= '0;
            sm_r      <= 1'b0;
            a_sgn     <= 1'b0;
            b_sgn     <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy      <= 1'b0;
            done_sig  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_sig <= 1'b0;
                    busy     <= start_sig;
                    if (start_sig) begin
                        sm_r     <= signed_mode;
                        a_sgn    <= dividend[WIDTH-1];
                        b_sgn    <= divisor[WIDTH-1];
                        a_raw    <= dividend;
                        b_mag    <= b_mag_in;
                        work     <= {{WIDTH{1'b0}}, a_mag_in};
                        div0_r   <= (divisor == '0);
                        ovf_r    <= signed_mode && (dividend == MIN_VAL) && (&divisor);
                        step_cnt <= '0;
                    end
                end
                CALC: begin
                    work     <= work_next;
                    step_cnt <= step_cnt + CW'(1);
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= div0_r;
                    overflow  <= ovf_r;
                end
                DONE: begin
                    done_sig <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_streamlined_divider_param.sv
// Self-checking bench: directed cases at WIDTH=8, exhaustive WIDTH=4,
// randomized WIDTH=16, all against an arithmetic reference model.
module tb_streamlined_divider_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic        s8_start, s8_sm, s8_busy, s8_done, s8_dz, s8_ov;
    logic [7:0]  s8_a, s8_b, s8_q, s8_r;
    logic        s4_start, s4_sm, s4_busy, s4_done, s4_dz, s4_ov;
    logic [3:0]  s4_a, s4_b, s4_q, s4_r;
    logic        s16_start, s16_sm, s16_busy, s16_done, s16_dz, s16_ov;
    logic [15:0] s16_a, s16_b, s16_q, s16_r;

    streamlined_divider_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_sig(s8_start), .signed_mode(s8_sm),
        .dividend(s8_a), .divisor(s8_b), .busy(s8_busy), .done_sig(s8_done),
        .quotient(s8_q), .remainder(s8_r), .div_zero(s8_dz), .overflow(s8_ov));

    streamlined_divider_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start_sig(s4_start), .signed_mode(s4_sm),
        .dividend(s4_a), .divisor(s4_b), .busy(s4_busy), .done_sig(s4_done),
        .quotient(s4_q), .remainder(s4_r), .div_zero(s4_dz), .overflow(s4_ov));

    streamlined_divider_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start_sig(s16_start), .signed_mode(s16_sm),
        .dividend(s16_a), .divisor(s16_b), .busy(s16_busy), .done_sig(s16_done),
        .quotient(s16_q), .remainder(s16_r), .div_zero(s16_dz), .overflow(s16_ov));

    // Reference: plain integer division, C truncation, special cases by rule.
    task automatic ref_div(input int w, input bit sm, input longint a, input longint b,
                           output longint q, output longint r, output bit dz, output bit ov);
        longint mask, half, sa, sb;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = mask;
            r  = a;
            dz = 1'b1;
        end else if (sm) begin
            sa = (a >= half) ? a - (mask + 1) : a;
            sb = (b >= half) ? b - (mask + 1) : b;
            if (sa == -half && sb == -1) begin
                q  = a;
                r  = 0;
                ov = 1'b1;
            end else begin
                q = (sa / sb) & mask;
                r = (sa % sb) & mask;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic drive(input int w, input bit st, input bit sm, input logic [15:0] a, input logic [15:0] b);
        case (w)
            4:       begin s4_start  = st; s4_sm  = sm; s4_a  = a[3:0]; s4_b  = b[3:0]; end
            8:       begin s8_start  = st; s8_sm  = sm; s8_a  = a[7:0]; s8_b  = b[7:0]; end
            default: begin s16_start = st; s16_sm = sm; s16_a = a;      s16_b = b;      end
        endcase
    endtask

    function automatic bit get_done(input int w);
        case (w)
            4:       return s4_done;
            8:       return s8_done;
            default: return s16_done;
        endcase
    endfunction

    // Issues one operation, scrambles the inputs after the accept edge and
    // returns the outputs seen in the done cycle; lat = -1 if done never came.
    task automatic do_op(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output bit dz, output bit ov, output int lat);
        @(negedge clk);
        drive(w, 1'b1, sm, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, ~sm, ~a, ~b);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_done(w)) begin
                lat = n;
                break;
            end
        end
        case (w)
            4:       begin q = {12'd0, s4_q}; r = {12'd0, s4_r}; dz = s4_dz;  ov = s4_ov;  end
            8:       begin q = {8'd0, s8_q};  r = {8'd0, s8_r};  dz = s8_dz;  ov = s8_ov;  end
            default: begin q = s16_q;         r = s16_r;         dz = s16_dz; ov = s16_ov; end
        endcase
    endtask

    task automatic test_reset();
        drive(4, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #12;
        n_total++; if (s8_busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", s8_busy);  else n_pass++;
        n_total++; if (s8_done !== 1'b0)  $display("FAIL reset_done: got %b want 0", s8_done);  else n_pass++;
        n_total++; if (s8_q !== 8'h00)    $display("FAIL reset_q: got %h want 00", s8_q);       else n_pass++;
        n_total++; if (s8_r !== 8'h00)    $display("FAIL reset_r: got %h want 00", s8_r);       else n_pass++;
        n_total++; if ({s8_dz, s8_ov} !== 2'b00) $display("FAIL reset_flags: got %b%b want 00", s8_dz, s8_ov); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] q, r; bit dz, ov; int lat;
        do_op(8, 0, 16'd200, 16'd7, q, r, dz, ov, lat);
        n_total++; if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat); else n_pass++;
        n_total++; if (q[7:0] !== 8'h1C || r[7:0] !== 8'h04 || dz || ov)
            $display("FAIL basic_result: got q=%h r=%h dz=%b ov=%b want q=1c r=04 dz=0 ov=0", q[7:0], r[7:0], dz, ov);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (s8_done !== 1'b0 || s8_busy !== 1'b0)
            $display("FAIL basic_pulse: got done=%b busy=%b want done=0 busy=0", s8_done, s8_busy);
        else n_pass++;
    endtask

    task automatic test_signs();
        logic [15:0] q, r; bit dz, ov; int lat;
        logic [7:0] ta [3] = '{8'hF9, 8'h07, 8'hF9};
        logic [7:0] tb [3] = '{8'h02, 8'hFE, 8'hFE};
        logic [7:0] tq [3] = '{8'hFD, 8'hFD, 8'h03};
        logic [7:0] tr [3] = '{8'hFF, 8'h01, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            do_op(8, 1, {8'd0, ta[i]}, {8'd0, tb[i]}, q, r, dz, ov, lat);
            n_total++;
            if (q[7:0] !== tq[i] || r[7:0] !== tr[i] || dz || ov || lat != 10)
                $display("FAIL signs_%0d: got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h flags 0 lat=10",
                         i, q[7:0], r[7:0], dz, ov, lat, tq[i], tr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_special();
        logic [15:0] q, r; bit dz, ov; int lat;
        do_op(8, 0, 16'd37, 16'd0, q, r, dz, ov, lat);
        n_total++; if (q[7:0] !== 8'hFF || r[7:0] !== 8'h25 || !dz || ov || lat != 10)
            $display("FAIL div_zero: got q=%h r=%h dz=%b ov=%b lat=%0d want q=ff r=25 dz=1 ov=0 lat=10", q[7:0], r[7:0], dz, ov, lat);
        else n_pass++;
        do_op(8, 1, 16'h80, 16'hFF, q, r, dz, ov, lat);
        n_total++; if (q[7:0] !== 8'h80 || r[7:0] !== 8'h00 || dz || !ov)
            $display("FAIL overflow: got q=%h r=%h dz=%b ov=%b want q=80 r=00 dz=0 ov=1", q[7:0], r[7:0], dz, ov);
        else n_pass++;
        do_op(8, 0, 16'h80, 16'hFF, q, r, dz, ov, lat);
        n_total++; if (q[7:0] !== 8'h00 || r[7:0] !== 8'h80 || dz || ov)
            $display("FAIL unsigned_no_ovf: got q=%h r=%h dz=%b ov=%b want q=00 r=80 flags 0", q[7:0], r[7:0], dz, ov);
        else n_pass++;
        do_op(8, 0, 16'd37, 16'd0, q, r, dz, ov, lat);
        do_op(8, 1, 16'd50, 16'd6, q, r, dz, ov, lat);
        n_total++; if (q[7:0] !== 8'd8 || r[7:0] !== 8'd2 || dz || ov)
            $display("FAIL flags_clear: got q=%h r=%h dz=%b ov=%b want q=08 r=02 flags 0", q[7:0], r[7:0], dz, ov);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int lat;
        bit extra;
        @(negedge clk);
        drive(8, 1, 0, 16'd100, 16'd3);
        @(posedge clk);
        #1 drive(8, 0, 0, 16'd100, 16'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(8, 1, 1, 16'h90, 16'd5);
        @(negedge clk);
        drive(8, 0, 1, 16'h90, 16'd5);
        lat = -1;
        for (int n = 4; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s8_done) begin lat = n; break; end
        end
        n_total++; if (lat != 10 || s8_q !== 8'd33 || s8_r !== 8'd1)
            $display("FAIL ignore_start: got lat=%0d q=%h r=%h want lat=10 q=21 r=01", lat, s8_q, s8_r);
        else n_pass++;
        extra = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (s8_done || s8_busy) extra = 1'b1;
        end
        n_total++; if (extra !== 1'b0) $display("FAIL ignore_no_second: got activity=%b want 0", extra); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int times[$];
        int t;
        @(negedge clk);
        drive(8, 1, 0, 16'd150, 16'd11);
        t = 0;
        while (t < 80 && times.size() < 4) begin
            t++;
            @(posedge clk);
            @(negedge clk);
            if (s8_done) begin
                times.push_back(t);
                n_total++; if (s8_q !== 8'd13 || s8_r !== 8'd7)
                    $display("FAIL b2b_result: got q=%h r=%h want q=0d r=07", s8_q, s8_r);
                else n_pass++;
                if (times.size() == 4) drive(8, 0, 0, 16'd150, 16'd11);
            end
        end
        drive(8, 0, 0, 16'd150, 16'd11);
        n_total++; if (times.size() != 4 || times[0] != 11)
            $display("FAIL b2b_count: got %0d results first at %0d want 4 results first at 11",
                     times.size(), (times.size() > 0) ? times[0] : -1);
        else n_pass++;
        for (int i = 1; i < times.size(); i++) begin
            n_total++; if (times[i] - times[i-1] != 11)
                $display("FAIL b2b_interval: got %0d want 11", times[i] - times[i-1]);
            else n_pass++;
        end
        @(posedge clk);
        @(negedge clk);
        n_total++; if (s8_busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", s8_busy); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [15:0] q, r; bit dz, ov; int lat;
        bit seen;
        @(negedge clk);
        drive(8, 1, 0, 16'd200, 16'd7);
        @(posedge clk);
        #1 drive(8, 0, 0, 16'd200, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (s8_busy !== 1'b1 || s8_q !== 8'd13)
            $display("FAIL midrst_pre: got busy=%b q=%h want busy=1 q=0d", s8_busy, s8_q);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++; if ({s8_busy, s8_done, s8_q, s8_r, s8_dz, s8_ov} !== 20'd0)
            $display("FAIL midrst_outputs: got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
                     s8_busy, s8_done, s8_q, s8_r, s8_dz, s8_ov);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (s8_done) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_done: got done seen=%b want 0", seen); else n_pass++;
        do_op(8, 0, 16'd99, 16'd10, q, r, dz, ov, lat);
        n_total++; if (q[7:0] !== 8'd9 || r[7:0] !== 8'd9 || dz || ov || lat != 10)
            $display("FAIL midrst_fresh: got q=%h r=%h dz=%b ov=%b lat=%0d want q=09 r=09 flags 0 lat=10", q[7:0], r[7:0], dz, ov, lat);
        else n_pass++;
    endtask

    task automatic test_exhaustive4();
        logic [15:0] q, r; bit dz, ov; int lat;
        longint eq, er; bit edz, eov;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    do_op(4, m[0], 16'(a), 16'(b), q, r, dz, ov, lat);
                    ref_div(4, m[0], longint'(a), longint'(b), eq, er, edz, eov);
                    n_total++;
                    if (q !== 16'(eq) || r !== 16'(er) || dz !== edz || ov !== eov || lat != 6)
                        $display("FAIL w4 sm=%0d %0d/%0d: got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h dz=%b ov=%b lat=6",
                                 m, a, b, q[3:0], r[3:0], dz, ov, lat, eq[3:0], er[3:0], edz, eov);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] q, r, a, b; bit dz, ov, sm; int lat;
        longint eq, er; bit edz, eov;
        for (int i = 0; i < 300; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 9))
                0: b = 16'h0000;
                1: begin sm = 1'b1; a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'($urandom_range(1, 9));
                3: b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: ;
            endcase
            do_op(16, sm, a, b, q, r, dz, ov, lat);
            ref_div(16, sm, longint'(a), longint'(b), eq, er, edz, eov);
            n_total++;
            if (q !== 16'(eq) || r !== 16'(er) || dz !== edz || ov !== eov || lat != 18)
                $display("FAIL w16 sm=%0d %h/%h: got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h dz=%b ov=%b lat=18",
                         sm, a, b, q, r, dz, ov, lat, eq[15:0], er[15:0], edz, eov);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive4();
        test_random16();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/streamlined_divider_param.md
Name: streamlined_divider_param

Overview:
- Iterative restoring divider, generalised to WIDTH bits, with a runtime-selectable signed/unsigned mode.
- Signed results use C-style truncation: the quotient sign is correct and the remainder takes the dividend's sign.
- Flags divide-by-zero and signed overflow.
- Sits beside the arithmetic blocks as a multi-cycle coprocessor with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_sig  in  1  request pulse; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- busy  out  1  high from the accept edge until done_sig deasserts.
- done_sig  out  1  one-cycle completion strobe.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_zero  out  1  divisor was 0 (valid with done_sig, held).
- overflow  out  1  signed MIN / -1 (valid with done_sig, held).

Behaviour:
- Reset (async, any time, including mid-operation):
  - State returns to IDLE.
  - busy, done_sig, quotient, remainder, div_zero and overflow all go to 0.
  - Internal registers are cleared; the in-flight operation is discarded.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, accept (edge k with start_sig=1):
  - Capture signed_mode and the operand signs.
  - Load |dividend| and |divisor| as WIDTH-bit unsigned magnitudes. |MIN| fits unsigned; unsigned mode uses operands as-is.
  - Clear the step counter; busy<=1; go to CALC.
- CALC, exactly WIDTH cycles, one restoring step per cycle on a 2*WIDTH-bit working register:
  - Shift left one bit.
  - Trial-subtract the magnitude divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and set quotient LSB 1; else restore and set LSB 0.
- FIX, one cycle:
  - Negate the quotient if the operand signs differ (signed mode).
  - Negate the remainder if the dividend is negative (signed mode).
  - Apply the special cases below.
  - Register quotient, remainder and flags.
- DONE, one cycle: done_sig=1, busy=1. Next edge: done_sig=0, busy=0, IDLE.
- Latency:
  - done_sig is high in the cycle after edge k+WIDTH+2.
  - A new start is accepted no earlier than edge k+WIDTH+3 (throughput WIDTH+3 cycles).
- Outputs hold their last values until the next FIX. The flags are cleared in FIX when the condition is absent.
- start_sig while busy is ignored, with no queueing. Operand changes after the accept edge have no effect.
- Divisor == 0 (either mode), same latency:
  - quotient = all ones; remainder = dividend unchanged; div_zero=1; overflow=0.
- Signed mode, dividend == MIN (1 followed by WIDTH-1 zeros) and divisor == all ones (-1):
  - quotient = MIN; remainder = 0; overflow=1.
- Unsigned mode never sets overflow.
- Arithmetic invariant (no flag): dividend == quotient*divisor + remainder, with |remainder| < |divisor|, in the selected interpretation.

Decomposition:
- Package div_pkg:
  - State encoding localparams (IDLE, CALC, FIX, DONE).
  - Function returning the step-counter width, $clog2(WIDTH+1).
- Sub-module div_restore_step, combinational, parameter WIDTH:
  - Inputs: working register and divisor magnitude.
  - Output: next working register.
  - Top instantiates it once, feeding it the registered state each CALC cycle.

Test Plan:
- WIDTH=8, unsigned, 200/7 -> after WIDTH+2 cycles done_sig pulses 1 cycle; quotient=28 (0x1C), remainder=4, flags 0.
- WIDTH=8, signed, the following sign cases (flags 0 in every case):
  - -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1).
  - 7/-2 -> quotient=0xFD, remainder=0x01.
  - -7/-2 -> quotient=0x03, remainder=0xFF.
- Special cases:
  - Unsigned 37/0 -> quotient=0xFF, remainder=0x25, div_zero=1.
  - Signed 0x80/0xFF -> quotient=0x80, remainder=0x00, overflow=1.
  - A following normal op clears both flags.
- Handshake:
  - Pulse start_sig again 3 cycles after accept with different operands -> ignored, first result returned.
  - Start held high continuously -> back-to-back results, done_sig every WIDTH+3 cycles.
- Assert rst mid-CALC (cycle 4):
  - All outputs 0 immediately (asynchronously), no done_sig.
  - After release, a fresh start completes correctly.
- WIDTH=4 exhaustive, both modes, all 256 operand pairs -> match the reference model including flags. Repeat randomized at WIDTH=16.
